// File: rtl/temperature_analyzer.sv
// Temperature classifier: registered LOW/HIGH abnormality flags with run-length
// persistence, saturating abnormal-sample counters and min/max tracking since reset.
module temperature_analyzer #(
  parameter int unsigned TEMP_W     = 8,
  parameter int unsigned LOW_LIMIT  = 35,
  parameter int unsigned HIGH_LIMIT = 39,
  parameter int unsigned PERSIST    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temperature,
  output logic              lowTempAbnormality,
  output logic              highTempAbnormality,
  output logic              tempNormal,
  output logic [TEMP_W-1:0] minTemp,
  output logic [TEMP_W-1:0] maxTemp,
  output logic [CNT_W-1:0]  lowCount,
  output logic [CNT_W-1:0]  highCount
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_LOW    = 2'd1,
    CLS_HIGH   = 2'd2
  } temp_class_e;

  localparam logic [TEMP_W-1:0] LOW_L     = TEMP_W'(LOW_LIMIT);
  localparam logic [TEMP_W-1:0] HIGH_L    = TEMP_W'(HIGH_LIMIT);
  localparam logic [3:0]        PERSIST_L = 4'(PERSIST);

  temp_class_e       cls;
  temp_class_e       run_class_q, run_class_d;
  logic [3:0]        run_cnt_q, run_cnt_d;
  logic              first_q, first_d;
  logic              low_q, low_d;
  logic              high_q, high_d;
  logic              normal_q, normal_d;
  logic [TEMP_W-1:0] min_q, min_d;
  logic [TEMP_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cls = CLS_NORMAL;
    if (temperature < LOW_L) begin
      cls = CLS_LOW;
    end else if (temperature > HIGH_L) begin
      cls = CLS_HIGH;
    end
  end

  always_comb begin
    run_class_d = cls;
    run_cnt_d   = 4'd1;
    first_d     = 1'b0;
    low_cnt_d   = low_cnt_q;
    high_cnt_d  = high_cnt_q;
    min_d       = min_q;
    max_d       = max_q;

    // A zero run count means no sample since reset, so the stored class is stale.
    if ((run_cnt_q != 4'd0) && (cls == run_class_q)) begin
      run_cnt_d = (run_cnt_q == 4'hF) ? run_cnt_q : run_cnt_q + 4'd1;
    end

    low_d    = (cls == CLS_LOW)  && (run_cnt_d >= PERSIST_L);
    high_d   = (cls == CLS_HIGH) && (run_cnt_d >= PERSIST_L);
    normal_d = ~(low_d | high_d);

    if ((cls == CLS_LOW) && (low_cnt_q != '1)) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end
    if ((cls == CLS_HIGH) && (high_cnt_q != '1)) begin
      high_cnt_d = high_cnt_q + 1'b1;
    end

    if (first_q) begin
      min_d = temperature;
      max_d = temperature;
    end else begin
      if (temperature < min_q) min_d = temperature;
      if (temperature > max_q) max_d = temperature;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values together.
    if (rst) begin
      run_class_q <= CLS_NORMAL;
      run_cnt_q   <= 4'd0;
      first_q     <= 1'b1;
      low_q       <= 1'b0;
      high_q      <= 1'b0;
      normal_q    <= 1'b1;
      min_q       <= '1;
      max_q       <= '0;
      low_cnt_q   <= '0;
      high_cnt_q  <= '0;
    end else begin
      run_class_q <= run_class_d;
      run_cnt_q   <= run_cnt_d;
      first_q     <= first_d;
      low_q       <= low_d;
      high_q      <= high_d;
      normal_q    <= normal_d;
      min_q       <= min_d;
      max_q       <= max_d;
      low_cnt_q   <= low_cnt_d;
      high_cnt_q  <= high_cnt_d;
    end
  end

  assign lowTempAbnormality  = low_q;
  assign highTempAbnormality = high_q;
  assign tempNormal          = normal_q;
  assign minTemp             = min_q;
  assign maxTemp             = max_q;
  assign lowCount            = low_cnt_q;
  assign highCount           = high_cnt_q;

endmodule

// File: tb/tb_temperature_analyzer.sv
// Bench for temperature_analyzer: three instances (defaults, PERSIST=3, CNT_W=4)
// share stimulus and are compared against a history-based reference model.
module tb_temperature_analyzer;

  localparam int LOW_LIM  = 35;
  localparam int HIGH_LIM = 39;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] temperature = 8'd0;

  logic        d_lo, d_hi, d_nm;
  logic [7:0]  d_mn, d_mx;
  logic [15:0] d_lc, d_hc;
  logic        p_lo, p_hi, p_nm;
  logic [7:0]  p_mn, p_mx;
  logic [15:0] p_lc, p_hc;
  logic        c_lo, c_hi, c_nm;
  logic [7:0]  c_mn, c_mx;
  logic [3:0]  c_lc, c_hc;

  int n_total = 0;
  int n_bad   = 0;
  int hist[$];

  always #5 clk = ~clk;

  temperature_analyzer u_def (
    .clk(clk), .rst(rst), .temperature(temperature),
    .lowTempAbnormality(d_lo), .highTempAbnormality(d_hi), .tempNormal(d_nm),
    .minTemp(d_mn), .maxTemp(d_mx), .lowCount(d_lc), .highCount(d_hc)
  );

  temperature_analyzer #(.PERSIST(3)) u_p3 (
    .clk(clk), .rst(rst), .temperature(temperature),
    .lowTempAbnormality(p_lo), .highTempAbnormality(p_hi), .tempNormal(p_nm),
    .minTemp(p_mn), .maxTemp(p_mx), .lowCount(p_lc), .highCount(p_hc)
  );

  temperature_analyzer #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .temperature(temperature),
    .lowTempAbnormality(c_lo), .highTempAbnormality(c_hi), .tempNormal(c_nm),
    .minTemp(c_mn), .maxTemp(c_mx), .lowCount(c_lc), .highCount(c_hc)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0 = normal, 1 = low, 2 = high
  function automatic int cls_of(input int t);
    if (t < LOW_LIM) return 1;
    if (t > HIGH_LIM) return 2;
    return 0;
  endfunction

  task automatic check_inst(input string pfx, input int persist, input int cnt_w,
                            input logic lo, input logic hi, input logic nm,
                            input int unsigned mn, input int unsigned mx,
                            input int unsigned lc, input int unsigned hc);
    int e_lo = 0, e_hi = 0, e_mn = 255, e_mx = 0, n_lo = 0, n_hi = 0, run = 0, last;
    int cap = (1 << cnt_w) - 1;
    if (hist.size() > 0) begin
      last = cls_of(hist[hist.size()-1]);
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (cls_of(hist[i]) != last) break;
        run++;
      end
      foreach (hist[i]) begin
        if (hist[i] < e_mn) e_mn = hist[i];
        if (hist[i] > e_mx) e_mx = hist[i];
        if (cls_of(hist[i]) == 1) n_lo++;
        if (cls_of(hist[i]) == 2) n_hi++;
      end
      e_lo = (last == 1 && run >= persist) ? 1 : 0;
      e_hi = (last == 2 && run >= persist) ? 1 : 0;
    end
    check({pfx, ".low"},    lo, e_lo);
    check({pfx, ".high"},   hi, e_hi);
    check({pfx, ".normal"}, nm, (e_lo == 0 && e_hi == 0) ? 1 : 0);
    check({pfx, ".min"},    mn, e_mn);
    check({pfx, ".max"},    mx, e_mx);
    check({pfx, ".lowcnt"}, lc, (n_lo > cap) ? cap : n_lo);
    check({pfx, ".highcnt"}, hc, (n_hi > cap) ? cap : n_hi);
  endtask

  task automatic check_all();
    check_inst("def", 1, 16, d_lo, d_hi, d_nm, d_mn, d_mx, d_lc, d_hc);
    check_inst("p3",  3, 16, p_lo, p_hi, p_nm, p_mn, p_mx, p_lc, p_hc);
    check_inst("c4",  1, 4,  c_lo, c_hi, c_nm, c_mn, c_mx, c_lc, c_hc);
  endtask

  // Called at a falling edge: drive, let the rising edge happen, check at next fall.
  task automatic step(input int t, input logic r);
    temperature = 8'(t);
    rst = r;
    @(posedge clk);
    if (r) hist.delete();
    else hist.push_back(t);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int seq32[6] = '{30, 30, 37, 30, 30, 30};
    int sweep[6] = '{34, 35, 39, 40, 0, 255};
    int exp_lo[6] = '{1, 0, 0, 0, 1, 0};
    int exp_hi[6] = '{0, 0, 0, 1, 0, 1};
    int t;

    @(negedge clk);
    step(99, 1'b1);
    check("reset.normal", d_nm, 1);
    check("reset.min", d_mn, 255);

    step(32, 1'b0); check("r030.a.low", d_lo, 1); check("r030.a.norm", d_nm, 0);
    step(37, 1'b0); check("r030.b.norm", d_nm, 1);
    step(40, 1'b0); check("r030.c.high", d_hi, 1); check("r030.c.norm", d_nm, 0);

    foreach (sweep[i]) begin
      step(sweep[i], 1'b0);
      check($sformatf("r031.low@%0d", sweep[i]), d_lo, exp_lo[i]);
      check($sformatf("r031.high@%0d", sweep[i]), d_hi, exp_hi[i]);
    end

    step(0, 1'b1);
    foreach (seq32[i]) begin
      step(seq32[i], 1'b0);
      check($sformatf("r032.low#%0d", i), p_lo, (i == 5) ? 1 : 0);
    end
    check("r032.lowcnt", p_lc, 5);

    step(0, 1'b1);
    step(50, 1'b0); step(20, 1'b0); step(37, 1'b0);
    check("r033.min", d_mn, 20); check("r033.max", d_mx, 50);
    check("r033.hc", d_hc, 1);   check("r033.lc", d_lc, 1);

    for (int i = 0; i < 10; i++) step(40, 1'b0);
    step(40, 1'b1);
    check("r034.rst.hc", d_hc, 0); check("r034.rst.max", d_mx, 0);
    step(37, 1'b0);
    check("r034.high", d_hi, 0); check("r034.min", d_mn, 37); check("r034.max", d_mx, 37);

    step(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(10, 1'b0);
      check($sformatf("r035.lc#%0d", i), c_lc, (i + 1 > 15) ? 15 : i + 1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 3) begin
        step($urandom_range(255), 1'b1);
      end else begin
        if ($urandom_range(99) < 75) t = $urandom_range(44, 28);
        else t = $urandom_range(255);
        step(t, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/temperature_analyzer.md
TEMPERATURE_ANALYZER -- requirements
Module: temperature_analyzer

Interface
REQ-001 Parameter TEMP_W, default 8, the unsigned temperature sample width in degrees.
REQ-002 Parameter LOW_LIMIT, default 35, the lowest normal temperature, inclusive.
REQ-003 Parameter HIGH_LIMIT, default 39, the highest normal temperature, inclusive; LOW_LIMIT <= HIGH_LIMIT SHALL hold.
REQ-004 Parameter PERSIST, default 1, range 1..15, the number of consecutive same-class samples needed to raise a flag.
REQ-005 Parameter CNT_W, default 16, the width of the abnormal-sample counters.
REQ-006 clk  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 temperature  input  TEMP_W  unsigned sample, taken on every clock edge.
REQ-009 lowTempAbnormality  output  1  registered low-temperature flag.
REQ-010 highTempAbnormality  output  1  registered high-temperature flag.
REQ-011 tempNormal  output  1  registered flag, asserted when neither abnormality flag is asserted.
REQ-012 minTemp  output  TEMP_W  lowest sample since reset.
REQ-013 maxTemp  output  TEMP_W  highest sample since reset.
REQ-014 lowCount  output  CNT_W  number of low samples since reset.
REQ-015 highCount  output  CNT_W  number of high samples since reset.

Function
REQ-016 Each sample SHALL be classified with unsigned compares:
- LOW if temperature < LOW_LIMIT.
- HIGH if temperature > HIGH_LIMIT.
- NORMAL otherwise, with both limits inclusive.
REQ-017 The block SHALL keep a 4-bit run counter and a run-class register.
- Same class as the previous sample: the counter increments, saturating at 15.
- Different class: the counter loads 1.
REQ-018 lowTempAbnormality SHALL be 1 at the edge where the LOW run length is >= PERSIST, and 0 otherwise.
- With PERSIST=1 the flag follows the sample with exactly one cycle of latency.
REQ-019 highTempAbnormality SHALL follow the same rule as REQ-018 for HIGH runs.
REQ-020 The two abnormality flags SHALL never be 1 at the same time.
REQ-021 The first sample that breaks a run SHALL clear the corresponding flag at that same edge.
REQ-022 tempNormal SHALL equal NOT(lowTempAbnormality OR highTempAbnormality) and SHALL be registered, with the same timing as the flags.
REQ-023 On each non-reset edge, lowCount SHALL increment by 1 when the sample is LOW, and highCount when it is HIGH.
- Counting uses the raw class and is independent of PERSIST.
- Both counters saturate at all-ones and never wrap.
REQ-024 minTemp and maxTemp SHALL update as follows.
- First non-reset edge after reset: both load the sample.
- Later edges: minTemp = min(minTemp, sample) and maxTemp = max(maxTemp, sample).
REQ-025 All outputs SHALL come directly from registers, with no combinational path from temperature to any output.
REQ-026 Boundary values SHALL classify as follows:
- temperature = LOW_LIMIT and temperature = HIGH_LIMIT are NORMAL.
- LOW_LIMIT-1 is LOW.
- HIGH_LIMIT+1 is HIGH.
- 0 and all-ones SHALL be handled without overflow.

Reset
REQ-027 When rst=1 at a clock edge, that edge SHALL set:
- the flags to 0 and tempNormal to 1;
- lowCount and highCount to 0;
- minTemp to all-ones and maxTemp to 0;
- the run counter to 0, with the first-sample marker re-armed.
REQ-028 Reset SHALL take priority over sampling; the sample present during a reset edge is discarded.
REQ-029 A reset asserted mid-run SHALL restart persistence counting from zero.

Verification
REQ-030 Reset, then temperature = 32, 37 and 40 for one cycle each with defaults. After each following edge:
- low=1, high=0, tempNormal=0;
- low=0, high=0, tempNormal=1;
- low=0, high=1, tempNormal=0.
REQ-031 Boundary sweep with defaults:
- 34 gives low=1.
- 35 and 39 give both flags 0.
- 40 gives high=1.
- 0 gives low=1.
- 255 gives high=1.
REQ-032 PERSIST=3, samples 30, 30, 37, 30, 30, 30:
- low stays 0 until after the sixth sample, then becomes 1;
- lowCount = 5.
REQ-033 Samples 50, 20, 37 after reset: minTemp=20, maxTemp=50, highCount=1, lowCount=1.
REQ-034 Hold temperature = 40 for 10 cycles, assert rst for 1 cycle, then apply 37:
- during reset, all outputs return to their reset values at the next edge;
- afterwards high=0, highCount=0, and minTemp = maxTemp = 37.
REQ-035 CNT_W=4, 20 consecutive samples of 10: lowCount saturates at 15 and never wraps.
